// File: rtl/div_ctrl.sv
// div_ctrl: valid/ready sequencer around a restoring 32-bit divider (1 quotient bit per cycle).
// Define DIV_CTRL_EARLY_OUT_EN to finish trivially-small or divide-by-zero ops straight from IDLE.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  div_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dz_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [31:0] src1_q;
    logic [4:0]  cnt_q;

    logic        in_signed;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_nxt;
    logic [31:0] rem_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] fin_result;

    assign req_ready = ~rst & (state == IDLE);

    // Signed ops divide magnitudes; the signs are re-applied when the result is formed.
    assign in_signed = div_op[0] | div_op[1];
    assign abs1      = (in_signed && src1[31]) ? -src1 : src1;
    assign abs2      = (in_signed && src2[31]) ? -src2 : src2;

    // quo_q starts as the dividend and fills with quotient bits from the right.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign rem_nxt = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nxt = {quo_q[30:0], ~diff[32]};

    // NOTE: every output gets a default at the top so no path through the block can infer a latch.
    always_comb begin
        q_fix = q_neg_q ? -quo_nxt : quo_nxt;
        r_fix = r_neg_q ? -rem_nxt : rem_nxt;
        if (dz_q) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = src1_q;
        end
        fin_result = ({32{op_q[0] | op_q[2]}} & q_fix) |
                     ({32{op_q[1] | op_q[3]}} & r_fix);
    end

`ifdef DIV_CTRL_EARLY_OUT_EN
    logic        early_out;
    logic [31:0] early_result;

    // Quotient is 0 and remainder is the dividend itself whenever |src1| < |src2|.
    assign early_out    = (src2 == 32'd0) || (abs1 < abs2);
    assign early_result = ({32{div_op[0] | div_op[2]}} &
                           ((src2 == 32'd0) ? 32'hFFFF_FFFF : 32'd0)) |
                          ({32{div_op[1] | div_op[3]}} & src1);
`endif

    // NOTE: all state here updates with <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            result     <= 32'd0;
            cnt_q      <= 5'd0;
            op_q       <= 4'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            quo_q      <= 32'd0;
            rem_q      <= 32'd0;
            dvs_q      <= 32'd0;
            src1_q     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is IDLE & ~rst, so req_valid alone completes the handshake here.
                    if (req_valid) begin
                        op_q    <= div_op;
                        q_neg_q <= in_signed & (src1[31] ^ src2[31]);
                        r_neg_q <= in_signed & src1[31];
                        dz_q    <= (src2 == 32'd0);
                        src1_q  <= src1;
                        quo_q   <= abs1;
                        dvs_q   <= abs2;
                        rem_q   <= 32'd0;
                        cnt_q   <= 5'd0;
                        busy    <= 1'b1;
`ifdef DIV_CTRL_EARLY_OUT_EN
                        if (early_out) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            result     <= early_result;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        result     <= fin_result;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: the driver queues hand-computed results, the monitor checks them on handshake.
// Latency expectations follow DIV_CTRL_EARLY_OUT_EN when it is defined for the build.
module tb_div_ctrl;

    localparam logic [3:0] DIV_W  = 4'b0001;
    localparam logic [3:0] MOD_W  = 4'b0010;
    localparam logic [3:0] DIV_WU = 4'b0100;
    localparam logic [3:0] MOD_WU = 4'b1000;

`ifdef DIV_CTRL_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        req_valid  = 1'b0;
    logic        resp_ready = 1'b1;
    logic [3:0]  div_op     = 4'd0;
    logic [31:0] src1       = 32'd0;
    logic [31:0] src2       = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic        busy;
    logic [31:0] result;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    string       name_q[$];

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .div_op     (div_op),
        .src1       (src1),
        .src2       (src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for req_ready, presents one request for a single cycle and queues its expectation.
    task automatic do_req(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit early);
        int t;
        t = 0;
        while (!req_ready && t < 200) begin
            tick();
            t++;
        end
        if (!req_ready) begin
            check_int({name, "_accept_timeout"}, int'(req_ready), 1);
            return;
        end
        div_op    = op;
        src1      = a;
        src2      = b;
        req_valid = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back((EARLY_EN && early) ? 1 : 33);
        acc_q.push_back(cyc);
        name_q.push_back(name);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin : monitor
        bit    rv_prev;
        int    first;
        string nm;
        rv_prev = 1'b0;
        first   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rv_prev = 1'b0;
            end else begin
                if (resp_valid && !rv_prev) first = cyc;
                rv_prev = resp_valid;
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check32("unexpected_resp", {31'd0, resp_valid}, 32'd0);
                    end else begin
                        nm = name_q.pop_front();
                        check32(nm, result, exp_q.pop_front());
                        check_int({nm, "_latency"}, first - acc_q.pop_front(), lat_q.pop_front());
                    end
                    rv_prev = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        repeat (3) tick();
        check_int("rst_req_ready", int'(req_ready), 0);
        check_int("rst_resp_valid", int'(resp_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check32("rst_result", result, 32'd0);
        rst = 1'b0;
        #1;
        check_int("idle_req_ready", int'(req_ready), 1);

        // Basic op with cycle-accurate busy window.
        do_req("div_w_100_7", DIV_W, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
        check_int("t1_req_ready_drop", int'(req_ready), 0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check_int("t1_busy_cycles", n, 33);

        // Signed rounding, unsigned contrast, and corners.
        do_req("div_w_m100_7",   DIV_W,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
        do_req("mod_w_m100_7",   MOD_W,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0);
        do_req("mod_w_100_m7",   MOD_W,  32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0);
        do_req("div_w_m100_m7",  DIV_W,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0);
        do_req("mod_w_m100_m7",  MOD_W,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        do_req("div_wu_m100_7",  DIV_WU, 32'hFFFF_FF9C, 32'd7,         32'h2492_4916, 1'b0);
        do_req("mod_wu_m100_7",  MOD_WU, 32'hFFFF_FF9C, 32'd7,         32'd2,         1'b0);
        do_req("div_wu_max_2",   DIV_WU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 1'b0);
        do_req("mod_wu_max_2",   MOD_WU, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0);
        do_req("div_w_5_0",      DIV_W,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
        do_req("mod_w_5_0",      MOD_W,  32'd5,         32'd0,         32'd5,         1'b1);
        do_req("mod_w_m5_0",     MOD_W,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1);
        do_req("div_wu_m5_0",    DIV_WU, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1);
        do_req("div_w_min_m1",   DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        do_req("mod_w_min_m1",   MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
        do_req("div_w_min_min",  DIV_W,  32'h8000_0000, 32'h8000_0000, 32'd1,         1'b0);
        do_req("div_w_m7_7",     DIV_W,  32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFFF, 1'b0);
        do_req("mod_wu_3_7",     MOD_WU, 32'd3,         32'd7,         32'd3,         1'b1);
        do_req("div_w_0_5",      DIV_W,  32'd0,         32'd5,         32'd0,         1'b1);

        // Backpressure with operands disturbed during BUSY.
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            tick();
        end
        resp_ready = 1'b0;
        do_req("bp_div_wu_1000_10", DIV_WU, 32'd1000, 32'd10, 32'd100, 1'b0);
        src1 = 32'hDEAD_BEEF;
        src2 = 32'h0000_0003;
        n = 0;
        while (!resp_valid && n < 100) begin
            n++;
            tick();
        end
        check_int("bp_resp_valid", int'(resp_valid), 1);
        for (int i = 0; i < 10; i++) begin
            check32("bp_hold_result", result, 32'd100);
            check_int("bp_hold_req_ready", int'(req_ready), 0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check_int("bp_req_ready_after", int'(req_ready), 1);
        do_req("b2b_mod_wu_1000_7", MOD_WU, 32'd1000, 32'd7, 32'd6, 1'b0);

        // Reset in BUSY cycle 10 discards the in-flight op.
        do_req("rst_victim", DIV_W, 32'd100, 32'd7, 32'd14, 1'b0);
        repeat (9) tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        void'(acc_q.pop_back());
        void'(name_q.pop_back());
        #1;
        check_int("midrst_req_ready", int'(req_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_resp_valid", int'(resp_valid), 0);
        check32("midrst_result", result, 32'd0);
        check_int("midrst_req_ready_idle", int'(req_ready), 1);
        do_req("div_wu_9_3", DIV_WU, 32'd9, 32'd3, 32'd3, 1'b0);
        do_req("div_w_3_7",  DIV_W,  32'd3, 32'd7, 32'd0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            tick();
        end
        check_int("drain_pending", exp_q.size(), 0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
